mag_cal_ctrl: RTL
=================

MAG_CAL_CTRL -- requirements
Module: mag_cal_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_COUNT, default 256: number of accepted samples per calibration run (range 2..65535).
REQ-002 The block SHALL have parameter MIN_SPAN, default 16'd64: minimum required max-min span per axis for a valid calibration.
REQ-003 The block SHALL have port clk, input, 1 bit: 100 MHz system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cal_start, input, 1 bit: single-cycle request to begin a calibration run.
REQ-006 The block SHALL have port cal_abort, input, 1 bit: single-cycle request to cancel a run in progress.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: single-cycle strobe marking new magnetometer data.
REQ-008 The block SHALL have ports mag_x_in and mag_y_in, input, 16 bits signed each: raw magnetometer axes, sampled when sample_valid=1.
REQ-009 The block SHALL have ports mag_x_out and mag_y_out, output, 16 bits signed each: offset-corrected axes for the heading calculation.
REQ-010 The block SHALL have port out_valid, output, 1 bit: single-cycle strobe marking mag_x_out and mag_y_out as updated.
REQ-011 The block SHALL have ports offset_x and offset_y, output, 16 bits signed each: current hard-iron offsets.
REQ-012 The block SHALL have port cal_busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have ports cal_done and cal_error, output, 1 bit each: single-cycle result pulses.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, CLEAR, COLLECT, COMPUTE, REPORT.
REQ-015 IDLE -> CLEAR SHALL occur on cal_start=1; cal_start in any other state SHALL be ignored.
REQ-016 CLEAR SHALL last one cycle, then go to COLLECT.
- Sets min_x = min_y = +32767 and max_x = max_y = -32768.
- Sets sample counter = 0.
REQ-017 In COLLECT, each sample_valid SHALL update min/max per axis with a signed compare and increment the counter.
REQ-018 The transition COLLECT -> COMPUTE SHALL occur in the cycle after the sample that brings the counter to SAMPLE_COUNT.
REQ-019 sample_valid outside COLLECT SHALL NOT affect min/max or the counter.
REQ-020 COMPUTE SHALL last one cycle.
- span = max - min, computed in 17 bits, per axis.
- Candidate offset = (max + min) >>> 1, computed in 17 bits with an arithmetic shift, then truncated to 16 bits.
REQ-021 COMPUTE -> REPORT SHALL occur unconditionally; REPORT SHALL last one cycle, then go to IDLE.
REQ-022 In REPORT, if both spans >= MIN_SPAN, the block SHALL load the candidate offsets into offset_x/offset_y and pulse cal_done.
REQ-023 In REPORT, if either span < MIN_SPAN, the block SHALL pulse cal_error and leave offset_x/offset_y unchanged.
REQ-024 cal_abort in CLEAR, COLLECT or COMPUTE SHALL force IDLE on the next edge.
- Offsets are unchanged.
- No cal_done or cal_error pulse is issued.
REQ-025 cal_abort in REPORT or IDLE SHALL be ignored.
REQ-026 If cal_abort and cal_start are high in the same IDLE cycle, cal_start SHALL win.
REQ-027 Correction SHALL run in every state.
- On sample_valid, mag_*_out = saturate16(mag_*_in - offset_*), with the difference computed in 17 bits.
- The result clamps to [-32768, +32767].
- out_valid pulses one cycle after sample_valid (latency 1).
REQ-028 Correction SHALL use the offset value registered at the time of the sample.
- A sample coincident with the REPORT offset load uses the old offset.
REQ-029 mag_*_out SHALL hold its value between out_valid pulses.

Reset
REQ-030 On reset assertion, the block SHALL asynchronously set:
- state = IDLE;
- offset_x, offset_y, mag_x_out, mag_y_out = 0;
- out_valid, cal_busy, cal_done, cal_error = 0;
- min/max registers and counter = 0.
REQ-031 Reset asserted mid-run SHALL discard the run, and the block SHALL resume in IDLE with zero offsets after release.

Verification
REQ-032 With SAMPLE_COUNT=4 and cal_start followed by (x,y) samples (100,-50), (300,150), (200,50), (250,-20) -> REPORT pulses cal_done, offset_x=200, offset_y=50, and cal_busy falls one cycle later.
REQ-033 Same run with samples all within x 10..40 -> cal_error pulses, cal_done stays low, and offsets remain at their previous values.
REQ-034 With offset_x=200, send sample x=-32700 -> mag_x_out=-32768, with out_valid exactly one cycle after sample_valid.
REQ-035 cal_abort after 2 of 4 samples -> IDLE next cycle, no result pulses, and a fresh cal_start restarts from CLEAR with the counter at 0.
REQ-036 Reset pulse during COLLECT -> all outputs 0 immediately (asynchronously), and post-reset samples pass through uncorrected (offset 0).

Source files
------------

// File: rtl/mag_cal_ctrl.sv
// Magnetometer hard-iron calibration: collects per-axis min/max over a run,
// derives the centre offsets, and continuously corrects incoming samples.

module mag_cal_axis #(
  parameter logic [15:0] MIN_SPAN = 16'd64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               upd_i,
  input  logic               cmp_i,
  input  logic               load_i,
  input  logic               smp_i,
  input  logic signed [15:0] din_i,
  output logic signed [15:0] dout_o,
  output logic signed [15:0] off_o,
  output logic               span_ok_o
);
  logic signed [15:0] min_q, max_q, cand_q, off_q, dout_q;
  logic               ok_q;
  logic signed [16:0] sum, span, diff;
  logic signed [15:0] sat;

  always_comb begin
    sum  = 17'(max_q) + 17'(min_q);
    span = 17'(max_q) - 17'(min_q);
    diff = 17'(din_i) - 17'(off_q);
    sat  = diff[15:0];
    // 17-bit overflow into bit 15 means the 16-bit result must clamp
    if (diff[16] != diff[15]) sat = diff[16] ? 16'sh8000 : 16'sh7fff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q  <= '0;
      max_q  <= '0;
      cand_q <= '0;
      ok_q   <= 1'b0;
      off_q  <= '0;
      dout_q <= '0;
    end else begin
      if (clr_i) begin
        min_q <= 16'sh7fff;
        max_q <= 16'sh8000;
      end else if (upd_i) begin
        if (din_i < min_q) min_q <= din_i;
        if (din_i > max_q) max_q <= din_i;
      end
      if (cmp_i) begin
        cand_q <= 16'(sum >>> 1);
        ok_q   <= (span >= $signed({1'b0, MIN_SPAN}));
      end
      if (load_i) off_q  <= cand_q;
      if (smp_i)  dout_q <= sat;
    end
  end

  assign dout_o    = dout_q;
  assign off_o     = off_q;
  assign span_ok_o = ok_q;
endmodule

module mag_cal_ctrl #(
  parameter int          SAMPLE_COUNT = 256,
  parameter logic [15:0] MIN_SPAN     = 16'd64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cal_start,
  input  logic               cal_abort,
  input  logic               sample_valid,
  input  logic signed [15:0] mag_x_in,
  input  logic signed [15:0] mag_y_in,
  output logic signed [15:0] mag_x_out,
  output logic signed [15:0] mag_y_out,
  output logic               out_valid,
  output logic signed [15:0] offset_x,
  output logic signed [15:0] offset_y,
  output logic               cal_busy,
  output logic               cal_done,
  output logic               cal_error
);
  localparam int          NUM_AXES = 2;
  localparam logic [15:0] CNT_LAST = 16'(SAMPLE_COUNT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, COMPUTE, REPORT} state_t;
  state_t state_q, state_d;

  logic [15:0]                cnt_q, cnt_d;
  logic                       out_valid_q;
  logic [NUM_AXES-1:0][15:0]  din, dout, off;
  logic [NUM_AXES-1:0]        span_ok;
  logic                       clr, upd, cmp, load;

  assign din = {mag_y_in, mag_x_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= sample_valid;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (cal_start) state_d = CLEAR;
      CLEAR: begin
        cnt_d   = '0;
        state_d = cal_abort ? IDLE : COLLECT;
      end
      COLLECT: begin
        if (sample_valid) cnt_d = cnt_q + 16'd1;
        if (cal_abort)                            state_d = IDLE;
        else if (sample_valid && cnt_q == CNT_LAST) state_d = COMPUTE;
      end
      COMPUTE: state_d = cal_abort ? IDLE : REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cal_busy  = (state_q != IDLE);
    clr       = (state_q == CLEAR);
    upd       = (state_q == COLLECT) && sample_valid;
    cmp       = (state_q == COMPUTE);
    cal_done  = (state_q == REPORT) && (&span_ok);
    cal_error = (state_q == REPORT) && !(&span_ok);
    load      = cal_done;
  end

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    mag_cal_axis #(.MIN_SPAN(MIN_SPAN)) u_axis (
      .clk       (clk),
      .rst       (reset),
      .clr_i     (clr),
      .upd_i     (upd),
      .cmp_i     (cmp),
      .load_i    (load),
      .smp_i     (sample_valid),
      .din_i     (din[a]),
      .dout_o    (dout[a]),
      .off_o     (off[a]),
      .span_ok_o (span_ok[a])
    );
  end

  assign mag_x_out = dout[0];
  assign mag_y_out = dout[1];
  assign offset_x  = off[0];
  assign offset_y  = off[1];
  assign out_valid = out_valid_q;
endmodule
